// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory responder
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port RAM, per-byte write enable, registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BE_W; i++)
                if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with programmable wait states
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    dmem_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    dmem_req_t req_q, cur;
    logic err_q, live_err, cur_err, mem_en;
    logic [AW-1:0] idx;
    logic [WORD_W-1:0] mem_q;
    // The RAM access fires on the edge entering RESP; in IDLE (zero wait) it uses the live request
    always_comb begin
        cur      = state == IDLE ? dmem_req_t'{req_we, req_addr, req_wdata, req_be} : req_q;
        live_err = req_addr < BASE_ADDR || {1'b0, req_addr - BASE_ADDR} >= SPAN;
        cur_err  = state == IDLE ? live_err : err_q;
        idx      = AW'((cur.addr - BASE_ADDR) >> 2);
        mem_en   = state == IDLE ? req_valid && WAIT_CYCLES == 0 : state == WAIT && cnt == '0;
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
                cnt_n   = CNT_INIT;
            end
            WAIT: begin
                cnt_n   = cnt - 1'b1;
                state_n = cnt == '0 ? RESP : WAIT;
            end
            RESP: state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && req_valid) begin
                req_q <= cur;
                err_q <= live_err;
            end
        end
    end
    dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (cur.we && !cur_err),
        .idx   (idx),
        .wdata (cur.wdata),
        .be    (cur.be),
        .rdata (mem_q)
    );
    assign req_ready = rst && state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid && !req_q.we && !err_q ? mem_q : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for two responder configurations
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic va = 1'b0, vb = 1'b0, we = 1'b0, rr = 1'b0, sel = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0] be = '0;
    logic a_rdy, a_val, a_err, b_rdy, b_val, b_err;
    logic [31:0] a_rd, b_rd;
    logic m_rdy, m_val, m_err;
    logic [31:0] m_rd;
    int checks = 0, failures = 0;
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_ready(a_rdy), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .rsp_valid(a_val),
        .rsp_ready(rr), .rsp_rdata(a_rd), .rsp_err(a_err));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_ready(b_rdy), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .rsp_valid(b_val),
        .rsp_ready(rr), .rsp_rdata(b_rd), .rsp_err(b_err));
    always_comb begin
        m_rdy = sel ? b_rdy : a_rdy;
        m_val = sel ? b_val : a_val;
        m_err = sel ? b_err : a_err;
        m_rd  = sel ? b_rd : a_rd;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // lat counts rising edges from acceptance (edge N) to the first edge seeing rsp_valid high
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
        int t;
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b; rr = (hold == 0);
        t = 0;
        while (!m_rdy && t < 20) begin @(negedge clk); t++; end
        chk("req_ready_idle", m_rdy, 1);
        if (sel) vb = 1'b1; else va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0; vb = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!m_val && lat < 20) begin @(negedge clk); lat++; end
        rd = m_rd;
        er = m_err;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", m_val, 1);
            chk("hold_rdata", m_rd, rd);
            chk("hold_req_ready", m_rdy, 0);
            @(negedge clk);
        end
        rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr = 1'b0;
        chk("post_valid", m_val, 0);
        chk("post_rdata", m_rd, 0);
        chk("post_req_ready", m_rdy, 1);
    endtask
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tv[14];
    logic [31:0] rd;
    logic er;
    int lat;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tv[0]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0, 1'b0};
        tv[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        tv[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tv[3]  = '{1'b1, 32'h0000_0010, 32'h0000_5500, 4'h2, 32'h0, 1'b0};
        tv[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_55EF, 1'b0};
        tv[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
        tv[6]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
        tv[7]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        tv[8]  = '{1'b1, 32'h0000_0000, 32'hAAAA_AAAA, 4'h0, 32'h0, 1'b0};
        tv[9]  = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tv[10] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        tv[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        tv[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
        tv[13] = '{1'b0, 32'h0000_1003, 32'h0,         4'h0, 32'h0, 1'b1};
        repeat (2) @(negedge clk);
        chk("rst_req_ready", a_rdy, 0);
        chk("rst_rsp_valid", a_val, 0);
        chk("rst_rsp_err", a_err, 0);
        chk("rst_rsp_rdata", a_rd, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", a_rdy, 1);
        chk("rel_rsp_valid", a_val, 0);
        foreach (tv[i]) begin
            xact(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be, 0, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_err", i), er, tv[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat, 3);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("bp_rdata", rd, 32'hDEAD_55EF);
        chk("bp_err", er, 0);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h1111_1111; be = 4'hF; rr = 1'b1; va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_req_ready", a_rdy, 0);
        chk("midrst_rsp_valid", a_val, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        begin
            logic seen = 1'b0;
            repeat (5) begin @(negedge clk); seen = seen | a_val; end
            chk("midrst_no_response", seen, 0);
        end
        rr = 1'b0;
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("midrst_load_rdata", rd, 32'h0);
        sel = 1'b1;
        xact(1'b1, 32'h4, 32'h0000_0055, 4'hF, 0, rd, er, lat);
        chk("w0_store_err", er, 0);
        chk("w0_store_latency", lat, 1);
        xact(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
        chk("w0_load_rdata", rd, 32'h0000_0055);
        chk("w0_load_latency", lat, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's load/store port: accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and returns a response (read data or store acknowledge) over a second valid/ready handshake.
- Used as the memory model behind the pipeline core in simulation and as the on-chip data RAM wrapper in synthesis.
- Exercises the core's stall path on memory latency.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the backing array.
- WAIT_CYCLES, 2: wait states between request acceptance and response valid; 0 is legal.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1: clock, all state updates on rising edge.
- rst  in  1: asynchronous, active-low reset.
- req_valid  in  1: core presents a request.
- req_ready  out  1: responder can accept a request this cycle.
- req_we  in  1: 1 = store, 0 = load.
- req_addr  in  32: byte address; bits [1:0] ignored (word access, lanes selected by req_be).
- req_wdata  in  32: store data, already lane-aligned by the core.
- req_be  in  4: byte enables for stores; ignored for loads.
- rsp_valid  out  1: response available.
- rsp_ready  in  1: core accepts the response.
- rsp_rdata  out  32: full load word; 0 for stores and errors.
- rsp_err  out  1: address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).

Behaviour:
- Reset (rst=0, async assert, sync release):
  - FSM goes to IDLE and the wait counter clears.
  - Outputs: req_ready=0 while rst=0, then 1 in IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch we/addr/wdata/be and compute the word index (addr - BASE_ADDR) >> 2 plus the range check.
  - Next state: WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0, next state is RESP.
- Transition into RESP:
  - Store, in range: write enabled bytes of the latched wdata; rsp_rdata=0, rsp_err=0.
  - Load, in range: rsp_rdata = array word (value after any earlier store); rsp_err=0.
  - Out of range: no write; rsp_rdata=0; rsp_err=1.
  - rsp_valid=1.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1 at a rising edge.
  - On that edge go to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency: request accepted at edge N gives rsp_valid high from edge N+WAIT_CYCLES+1. With WAIT_CYCLES=0 that is the next cycle.
- Throughput: at most one request per WAIT_CYCLES+2 cycles. No back-to-back acceptance in the same cycle as the response handshake; req_ready rises the cycle after rsp handshake.
- Request signal changes while req_ready=0 are ignored; there is no buffering beyond one request.
- req_be=0 store: no bytes change, acknowledge still returned with rsp_err=0.
- Range check is done on the full 32-bit address, with no wrap-around.
- An address below BASE_ADDR is an error.
- Reset mid-operation (WAIT or RESP):
  - In-flight request is discarded and the response is dropped.
  - A store whose RESP-entry write already happened stays written; a store still in WAIT is never written.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef dmem_state_e {IDLE, WAIT, RESP};
  - localparams for word width (32) and byte-enable width (4);
  - struct dmem_req_t {we, addr, wdata, be} for the latched request.
- One sub-module, dmem_array: synchronous single-port RAM with per-byte write enable and registered read. It keeps the array inferable as block RAM. The FSM issues the read/write one cycle before RESP so the registered output aligns with RESP entry.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=0 during reset, then 1 on the first cycle after release.
- WAIT_CYCLES=2: store addr 32'h10, wdata 32'hDEADBEEF, be 4'hF accepted at edge N, rsp_ready=1 -> rsp_valid high at edge N+3, rsp_err=0. Then a load of 32'h10 -> rsp_rdata=32'hDEADBEEF.
- Partial store: addr 32'h10, wdata 32'h0000_5500, be 4'b0010 -> a following load returns 32'hDEAD55EF.
- Out of range with DEPTH_WORDS=1024: load of 32'h0000_1000 -> rsp_err=1, rsp_rdata=0. Store to the same address -> rsp_err=1, and a load of 32'h0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout. Raising rsp_ready gives one handshake, and req_ready=1 the cycle after.
- Reset mid-WAIT: store to 32'h20 (prior value 32'h0) accepted, assert rst=0 one cycle later -> no response, and a load of 32'h20 after release returns 32'h0.
- WAIT_CYCLES=0: load accepted at edge N -> rsp_valid at edge N+1.
